// File: rtl/rx_frame_assembler_if.sv
// Bus bundle for rx_frame_assembler: incoming control/data packet slots and the
// payload head (valid/ready) towards the consumer.
//   master: packet source + payload consumer
//   slave : the assembler itself
interface rx_frame_assembler_if #(
  parameter int DATA_W = 32,
  parameter int NODE_W = 16
);
  logic [DATA_W-1:0]        control_rx_packet;  // {src, len}; zero = idle slot
  logic [DATA_W-1:0]        data_rx_packet;     // {src, payload}; zero = idle slot
  logic                     out_valid;          // head entry valid
  logic                     out_ready;          // consumer pops when valid && ready
  logic [DATA_W-NODE_W-1:0] out_data;           // head payload
  logic [NODE_W-1:0]        out_src;            // head source id
  logic                     out_last;           // head is last word of its frame

  modport master (
    output control_rx_packet, data_rx_packet, out_ready,
    input  out_valid, out_data, out_src, out_last
  );

  modport slave (
    input  control_rx_packet, data_rx_packet, out_ready,
    output out_valid, out_data, out_src, out_last
  );
endinterface

// File: rtl/rx_frame_assembler.sv
// fifo: generic synchronous FIFO, head presented from the storage array.
// Latency: a write is visible at the head the cycle after it is written.
// Backpressure: writes are refused when full unless a read happens in the same cycle.
//   ports: clk, rst (sync, active high), wr_en/wr_data, rd_en/rd_data, empty, full
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Head reads as zero when empty so nothing undefined leaks out after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// rx_frame_assembler: validates a {src,len} header, then collects len words tagged
//   with that src, strips tags, marks the last word and queues payload for the consumer.
// Latency: first data word accepted the cycle after the header; pushed words reach the
//   head one cycle later; all status pulses fire the cycle after their cause.
// Backpressure: out_valid/out_ready pop; a matching word arriving while the FIFO is
//   full with no pop is dropped (err_overflow) and must be resent.
//   ports: clk, rst, node_id, max_node, bus (slave modport), frame_done, frame_abort,
//          err_len, err_src, err_overflow, frame_count
module rx_frame_assembler #(
  parameter int DATA_W     = 32,
  parameter int NODE_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          node_id,
  input  logic [15:0]          max_node,
  rx_frame_assembler_if.slave  bus,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 err_len,
  output logic                 err_src,
  output logic                 err_overflow,
  output logic [15:0]          frame_count
);
  localparam int PW = DATA_W - NODE_W;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, RECV} state_t;

  typedef struct packed {
    logic              last;
    logic [NODE_W-1:0] src;
    logic [PW-1:0]     payload;
  } entry_t;

  state_t            state, state_nxt;
  logic [NODE_W-1:0] src_q, src_nxt;
  logic [NODE_W-1:0] rem, rem_nxt;
  logic [IW-1:0]     idle_cnt, idle_nxt;
  logic              done_nxt, abort_nxt, len_nxt, src_err_nxt, ovf_nxt;
  logic              push;

  logic [NODE_W-1:0] hdr_src, hdr_len, tag;
  logic [PW-1:0]     payload;
  logic              hdr_ok, pop, room;
  logic              fifo_empty, fifo_full;
  entry_t            wr_entry, head;

  assign hdr_src = bus.control_rx_packet[DATA_W-1 -: NODE_W];
  assign hdr_len = bus.control_rx_packet[NODE_W-1:0];
  assign tag     = bus.data_rx_packet[DATA_W-1 -: NODE_W];
  assign payload = bus.data_rx_packet[PW-1:0];

  assign hdr_ok = (hdr_src != '0) && (hdr_src <= NODE_W'(max_node)) &&
                  (hdr_src != NODE_W'(node_id)) &&
                  (hdr_len != '0) && (hdr_len <= NODE_W'(FIFO_DEPTH));

  // A pop in the same cycle frees the slot the push needs.
  assign pop  = bus.out_valid && bus.out_ready;
  assign room = !fifo_full || pop;

  always_comb begin
    state_nxt   = state;
    src_nxt     = src_q;
    rem_nxt     = rem;
    idle_nxt    = idle_cnt;
    push        = 1'b0;
    done_nxt    = 1'b0;
    abort_nxt   = 1'b0;
    len_nxt     = 1'b0;
    src_err_nxt = 1'b0;
    ovf_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.control_rx_packet != '0) begin
          if (hdr_ok) begin
            state_nxt = RECV;
            src_nxt   = hdr_src;
            rem_nxt   = hdr_len;
            idle_nxt  = '0;
          end else begin
            len_nxt = 1'b1;
          end
        end
      end
      RECV: begin
        if (bus.data_rx_packet == '0) begin
          // This idle slot is the TIMEOUT-th in a row: give up on the frame.
          if (idle_cnt == IW'(TIMEOUT - 1)) begin
            abort_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            idle_nxt = idle_cnt + IW'(1);
          end
        end else begin
          idle_nxt = '0;
          if (tag != src_q) begin
            src_err_nxt = 1'b1;
          end else if (!room) begin
            ovf_nxt = 1'b1;
          end else begin
            push    = 1'b1;
            rem_nxt = rem - NODE_W'(1);
            if (rem == NODE_W'(1)) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      src_q        <= '0;
      rem          <= '0;
      idle_cnt     <= '0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
      err_len      <= 1'b0;
      err_src      <= 1'b0;
      err_overflow <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_nxt;
      src_q        <= src_nxt;
      rem          <= rem_nxt;
      idle_cnt     <= idle_nxt;
      frame_done   <= done_nxt;
      frame_abort  <= abort_nxt;
      err_len      <= len_nxt;
      err_src      <= src_err_nxt;
      err_overflow <= ovf_nxt;
      if (done_nxt) frame_count <= frame_count + 16'd1;
    end
  end

  assign wr_entry = '{last: (rem == NODE_W'(1)), src: src_q, payload: payload};

  fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (bus.out_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head.payload;
  assign bus.out_src   = head.src;
  assign bus.out_last  = head.last;
endmodule

// File: tb/tb_rx_frame_assembler.sv
// Bench for rx_frame_assembler: directed scenarios followed by random frames, every
// cycle compared against a queue-based reference of the frame rules.
module tb_rx_frame_assembler;
  localparam int DATA_W = 32;
  localparam int NODE_W = 16;
  localparam int DEPTH  = 4;
  localparam int TMO    = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] node_id  = 16'd1;
  logic [15:0] max_node = 16'd4;
  logic        frame_done, frame_abort, err_len, err_src, err_overflow;
  logic [15:0] frame_count;

  rx_frame_assembler_if #(.DATA_W(DATA_W), .NODE_W(NODE_W)) bus ();

  rx_frame_assembler #(
    .DATA_W(DATA_W), .NODE_W(NODE_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .node_id      (node_id),
    .max_node     (max_node),
    .bus          (bus),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .err_len      (err_len),
    .err_src      (err_src),
    .err_overflow (err_overflow),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // Reference model: frame bookkeeping in plain integers, FIFO as a queue.
  typedef struct {
    int src;
    int pay;
    bit last;
  } ent_t;

  ent_t mq[$];
  bit   m_in;
  int   m_src, m_rem, m_idle, m_count;
  bit   e_done, e_abort, e_len, e_src, e_ovf;
  int   checks = 0;
  int   errors = 0;

  task automatic model_step(input logic [31:0] c, input logic [31:0] d,
                            input bit rdy, input bit r);
    int  hs, hl, tg;
    bit  pop, blocked;
    e_done = 0; e_abort = 0; e_len = 0; e_src = 0; e_ovf = 0;
    if (r) begin
      mq.delete();
      m_in = 0; m_idle = 0; m_count = 0;
      return;
    end
    pop     = (mq.size() > 0) && rdy;
    blocked = (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (!m_in) begin
      if (c != 0) begin
        hs = int'(c[31:16]);
        hl = int'(c[15:0]);
        if (hs >= 1 && hs <= int'(max_node) && hs != int'(node_id) && hl >= 1 && hl <= DEPTH) begin
          m_in = 1; m_src = hs; m_rem = hl; m_idle = 0;
        end else begin
          e_len = 1;
        end
      end
    end else if (d == 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        e_abort = 1;
        m_in = 0;
      end
    end else begin
      m_idle = 0;
      tg = int'(d[31:16]);
      if (tg != m_src) e_src = 1;
      else if (blocked) e_ovf = 1;
      else begin
        mq.push_back('{src: m_src, pay: int'(d[15:0]), last: (m_rem == 1)});
        m_rem--;
        if (m_rem == 0) begin
          e_done = 1;
          m_count = (m_count + 1) & 16'hFFFF;
          m_in = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_data", 32'(bus.out_data), 32'(mq[0].pay));
      chk("out_src",  32'(bus.out_src),  32'(mq[0].src));
      chk("out_last", 32'(bus.out_last), 32'(mq[0].last));
    end
    chk("frame_done",   32'(frame_done),   32'(e_done));
    chk("frame_abort",  32'(frame_abort),  32'(e_abort));
    chk("err_len",      32'(err_len),      32'(e_len));
    chk("err_src",      32'(err_src),      32'(e_src));
    chk("err_overflow", 32'(err_overflow), 32'(e_ovf));
    chk("frame_count",  32'(frame_count),  32'(m_count));
  endtask

  // One clock slot: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input logic [31:0] c, input logic [31:0] d, input bit rdy, input bit r);
    bus.control_rx_packet = c;
    bus.data_rx_packet    = d;
    bus.out_ready         = rdy;
    rst                   = r;
    model_step(c, d, rdy, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bus.control_rx_packet = '0;
    bus.data_rx_packet    = '0;
    bus.out_ready         = 1'b0;

    // Reset state
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);

    // T1: basic 4-word frame from node 2, consumer always ready
    cyc(32'h0002_0004, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0002_000A + 32'(i), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("t1_count", 32'(frame_count), 32'd1);

    // T2: rejected headers (own id, above max, len 0, len > depth, src 0); data in IDLE ignored
    cyc(32'h0001_0004, 0, 1, 0);
    chk("t2_own_id", 32'(err_len), 32'd1);
    cyc(32'h0005_0002, 0, 1, 0);
    chk("t2_src_max", 32'(err_len), 32'd1);
    cyc(32'h0002_0000, 0, 1, 0);
    chk("t2_len0", 32'(err_len), 32'd1);
    cyc(32'h0002_0005, 0, 1, 0);
    cyc(32'h0000_0003, 0, 1, 0);
    cyc(0, 32'h0002_0001, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t2_no_write", 32'(bus.out_valid), 32'd0);

    // T3: wrong-tag word dropped; control slot ignored during RECV
    cyc(32'h0003_0002, 0, 1, 0);
    cyc(0, 32'h0002_000A, 1, 0);
    chk("t3_err_src", 32'(err_src), 32'd1);
    cyc(32'h0002_0001, 32'h0003_000B, 1, 0);
    cyc(0, 32'h0003_000C, 1, 0);
    chk("t3_done", 32'(frame_done), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

    // T4: consumer stalled; second frame overflows, then retried with pop+push while full
    cyc(32'h0002_0003, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 32'h0002_0010 + 32'(i), 0, 0);
    cyc(32'h0003_0002, 0, 0, 0);
    cyc(0, 32'h0003_0020, 0, 0);
    cyc(0, 32'h0003_0021, 0, 0);
    chk("t4_ovf", 32'(err_overflow), 32'd1);
    cyc(0, 32'h0003_0021, 1, 0);
    chk("t4_retry_done", 32'(frame_done), 32'd1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);

    // T5: timeout after one word, then a fresh frame is accepted
    cyc(32'h0002_0003, 0, 1, 0);
    cyc(0, 32'h0002_0005, 1, 0);
    for (int i = 1; i <= TMO; i++) begin
      cyc(0, 0, 1, 0);
      chk("t5_abort_slot", 32'(frame_abort), 32'(i == TMO));
    end
    cyc(32'h0004_0001, 0, 1, 0);
    cyc(0, 32'h0004_0009, 1, 0);
    chk("t5_next_frame", 32'(frame_done), 32'd1);
    cyc(0, 0, 1, 0);

    // T6: reset mid-frame clears FIFO and counter
    cyc(32'h0002_0003, 0, 0, 0);
    cyc(0, 32'h0002_0031, 0, 0);
    cyc(0, 32'h0002_0032, 0, 0);
    cyc(0, 0, 0, 1);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_count", 32'(frame_count), 32'd0);
    cyc(32'h0003_0002, 0, 1, 0);
    cyc(0, 32'h0003_0041, 1, 0);
    cyc(0, 32'h0003_0042, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

    // Random frames: mixed headers, gaps, wrong tags, stray control slots, random ready
    for (int f = 0; f < 60; f++) begin
      logic [31:0] hdr;
      hdr = {16'($urandom_range(0, 5)), 16'($urandom_range(0, 5))};
      cyc(hdr, 0, bit'($urandom_range(0, 9) < 7), 0);
      for (int k = 0; k < 30 && m_in; k++) begin
        int          sel;
        logic [31:0] d;
        logic [31:0] c;
        sel = int'($urandom_range(0, 9));
        c   = ($urandom_range(0, 9) == 0) ? 32'h0002_0001 : 32'h0;
        if (sel < 2)       d = 32'h0;
        else if (sel == 2) d = {16'((m_src % 4) + 1), 16'($urandom)};
        else               d = {16'(m_src), 16'($urandom)};
        cyc(c, d, bit'($urandom_range(0, 9) < 7), 0);
      end
      for (int k = 0; k < TMO && m_in; k++) cyc(0, 0, 1, 0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) cyc(0, 0, 1, 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 1, 0);
    chk("final_drained", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
